// File: rtl/bomb_ctrl.sv
// bomb_ctrl: game master for the bomb.
// Tracks strikes from the puzzle modules' boom flags and re-arms a module
// after it booms. Runs the 1 kHz countdown and reports DEFUSED or EXPLODED
// to the display/buzzer layer.
// Optional feature macro: STRIKE_SPEEDUP_EN. Each strike shortens every
// remaining second by a quarter of TICKS_PER_SEC.
module bomb_ctrl #(
    parameter int NUM_MOD       = 4,
    parameter int MAX_STRIKES   = 3,
    parameter int TIME_SEC      = 300,
    parameter int TW            = 9,
    parameter int TICKS_PER_SEC = 1000,
    parameter int RST_CYC       = 4
) (
    input  logic               Clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_MOD-1:0] mod_boom,
    input  logic [NUM_MOD-1:0] mod_done,
    output logic [NUM_MOD-1:0] mod_rst,
    output logic [TW-1:0]      time_left,
    output logic [2:0]         strikes,
    output logic               strike_pulse,
    output logic               defused,
    output logic               exploded,
    output logic               armed
);

    localparam int TKW = $clog2(TICKS_PER_SEC + 1);
    localparam int CW  = $clog2(RST_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARMED,
        S_DEFUSED,
        S_EXPLODED
    } state_t;

    state_t             state;
    state_t             armed_next;
    logic [TKW-1:0]     tick;
    logic [CW-1:0]      clr_cnt;
    logic [CW-1:0]      rearm_cnt [NUM_MOD];
    logic [NUM_MOD-1:0] done_lat;
    logic [NUM_MOD-1:0] boom_q;

    logic [NUM_MOD-1:0] masked;
    logic [NUM_MOD-1:0] new_boom;
    logic [NUM_MOD-1:0] done_set;
    logic [NUM_MOD-1:0] done_next;
    logic [2:0]         strikes_next;
    int                 boom_cnt;
    int                 strike_sum;
    int                 tick_limit;
    logic               tick_wrap;

`ifdef STRIKE_SPEEDUP_EN
    // Length of the current second shrinks by a quarter per strike, never below one tick.
    always_comb begin
        tick_limit = TICKS_PER_SEC - int'(strikes) * (TICKS_PER_SEC / 4);
        if (tick_limit < 1) tick_limit = 1;
    end
`else
    assign tick_limit = TICKS_PER_SEC;
`endif

    // Per-cycle game decisions: new strikes, done latching, timer wrap and ARMED exit.
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        masked    = mod_rst | done_lat;
        new_boom  = '0;
        done_set  = '0;
        if (state == S_ARMED) begin
            new_boom = mod_boom & ~boom_q & ~masked;
            // A module booming and finishing in the same cycle counts as a boom.
            done_set = mod_done & ~mod_rst & ~new_boom;
        end
        done_next = done_lat | done_set;

        boom_cnt = 0;
        for (int i = 0; i < NUM_MOD; i++) boom_cnt = boom_cnt + int'(new_boom[i]);
        strike_sum   = int'(strikes) + boom_cnt;
        strikes_next = (strike_sum >= MAX_STRIKES) ? 3'(MAX_STRIKES) : 3'(strike_sum);

        // Using >= lets a second that is already past a freshly shortened limit end at once.
        tick_wrap = (int'(tick) >= tick_limit - 1);

        if (strikes_next == 3'(MAX_STRIKES))  armed_next = S_EXPLODED;
        else if (&done_next)                  armed_next = S_DEFUSED;
        else if (time_left == '0)             armed_next = S_EXPLODED;
        else                                  armed_next = S_ARMED;
    end

    // Game state machine with its counters and registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            time_left    <= TW'(TIME_SEC);
            strikes      <= '0;
            tick         <= '0;
            clr_cnt      <= '0;
            mod_rst      <= '0;
            strike_pulse <= 1'b0;
            defused      <= 1'b0;
            exploded     <= 1'b0;
            armed        <= 1'b0;
            done_lat     <= '0;
            boom_q       <= '0;
            // NOTE: the re-arm counters are a small register array, so each entry is reset explicitly.
            for (int i = 0; i < NUM_MOD; i++) rearm_cnt[i] <= '0;
        end else begin
            // Held in reset a module cannot be seen as booming, so it can strike again once released.
            boom_q       <= mod_boom & ~mod_rst;
            strike_pulse <= 1'b0;

            case (state)
                S_IDLE, S_DEFUSED, S_EXPLODED: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        defused   <= 1'b0;
                        exploded  <= 1'b0;
                        armed     <= 1'b0;
                        mod_rst   <= '1;
                        clr_cnt   <= CW'(RST_CYC - 1);
                        time_left <= TW'(TIME_SEC);
                        strikes   <= '0;
                        done_lat  <= '0;
                        tick      <= '0;
                    end
                end

                S_CLEAR: begin
                    if (clr_cnt == '0) begin
                        state   <= S_ARMED;
                        armed   <= 1'b1;
                        mod_rst <= '0;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end

                S_ARMED: begin
                    strikes      <= strikes_next;
                    done_lat     <= done_next;
                    strike_pulse <= |new_boom;
                    tick         <= tick_wrap ? '0 : tick + 1'b1;
                    if (tick_wrap && time_left != '0) time_left <= time_left - 1'b1;

                    for (int i = 0; i < NUM_MOD; i++) begin
                        if (new_boom[i]) begin
                            rearm_cnt[i] <= CW'(RST_CYC);
                            mod_rst[i]   <= 1'b1;
                        end else if (rearm_cnt[i] != '0) begin
                            rearm_cnt[i] <= rearm_cnt[i] - 1'b1;
                            mod_rst[i]   <= (rearm_cnt[i] != CW'(1));
                        end else begin
                            mod_rst[i]   <= 1'b0;
                        end
                    end

                    state    <= armed_next;
                    armed    <= (armed_next == S_ARMED);
                    defused  <= (armed_next == S_DEFUSED);
                    exploded <= (armed_next == S_EXPLODED);
                    if (armed_next != S_ARMED) begin
                        mod_rst <= '0;
                        for (int i = 0; i < NUM_MOD; i++) rearm_cnt[i] <= '0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
